ac_unit: RTL and testbench

Parametrised signed accumulator: successor to the 8-bit load-only AC register. Adds arithmetic ops (load, add, subtract, clear, negate, multi-cycle multiply), selectable saturate/wrap overflow handling and status flags. Sits between the switch/operand datapath and the seven-segment display driver; its AC output feeds the display unchanged.

---
 rtl/ac_unit.sv | 178 +++++++++++++++++
 tb/tb_ac_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ac_unit.sv
`default_nettype none
// ============================================================================
// Module   : ac_unit
// Purpose  : Signed accumulator with load/add/sub/clear/negate, a shift-add
//            multiplier, saturate or wrap overflow handling and status flags.
// Revision : 1.0 - initial release
// ============================================================================
module ac_unit #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Z,
    input  logic [2:0]       op,
    input  logic             op_valid,
    output logic [WIDTH-1:0] AC,
    output logic             busy,
    output logic             done,
    output logic             OVF,
    output logic             ZF,
    output logic             NF
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_VAL   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_NEG  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       ac, ac_nxt;
    logic                   ovf, ovf_nxt;
    logic                   done_q, done_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [2*WIDTH-1:0]     mcand, mcand_nxt;
    logic [2*WIDTH-1:0]     prod, prod_nxt;
    logic [WIDTH-1:0]       mplier, mplier_nxt;
    logic                   neg_res, neg_res_nxt;

    // Single-cycle arithmetic at WIDTH+1 bits so the true result is always exact
    logic [WIDTH:0]         ext_ac, ext_z, alu_res;
    logic                   alu_ovf;
    logic [WIDTH-1:0]       alu_val;
    logic [WIDTH-1:0]       mag_ac, mag_z;
    logic [2*WIDTH-1:0]     prod_fin, signed_prod;
    logic [WIDTH:0]         prod_hi;
    logic                   mul_ovf;
    logic [WIDTH-1:0]       mul_val;

    always_comb begin
        ext_ac  = {ac[WIDTH-1], ac};
        ext_z   = {Z[WIDTH-1], Z};
        alu_res = ext_ac + ext_z;
        case (op)
            OP_SUB:  alu_res = ext_ac - ext_z;
            OP_NEG:  alu_res = '0 - ext_ac;
            default: alu_res = ext_ac + ext_z;
        endcase
        alu_ovf = alu_res[WIDTH] ^ alu_res[WIDTH-1];
        alu_val = alu_res[WIDTH-1:0];
        if (SAT && alu_ovf) begin
            alu_val = alu_res[WIDTH] ? MIN_VAL : MAX_VAL;
        end

        // |MIN| = 2^(WIDTH-1) is representable as an unsigned WIDTH-bit magnitude
        mag_ac = ac[WIDTH-1] ? (~ac + 1'b1) : ac;
        mag_z  = Z[WIDTH-1]  ? (~Z + 1'b1)  : Z;

        prod_fin    = prod + (mplier[0] ? mcand : '0);
        signed_prod = neg_res ? (~prod_fin + 1'b1) : prod_fin;
        prod_hi     = signed_prod[2*WIDTH-1:WIDTH-1];
        mul_ovf     = ~((&prod_hi) | ~(|prod_hi));
        mul_val     = signed_prod[WIDTH-1:0];
        if (SAT && mul_ovf) begin
            mul_val = signed_prod[2*WIDTH-1] ? MIN_VAL : MAX_VAL;
        end
    end

    always_comb begin
        state_nxt   = state;
        ac_nxt      = ac;
        ovf_nxt     = ovf;
        done_nxt    = 1'b0;
        cnt_nxt     = cnt;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        prod_nxt    = prod;
        neg_res_nxt = neg_res;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_LOAD: begin
                            ac_nxt  = Z;
                            ovf_nxt = 1'b0;
                        end
                        OP_ADD, OP_SUB, OP_NEG: begin
                            ac_nxt = alu_val;
                            if (alu_ovf) ovf_nxt = 1'b1;
                        end
                        OP_CLR: begin
                            ac_nxt  = '0;
                            ovf_nxt = 1'b0;
                        end
                        OP_MUL: begin
                            state_nxt   = MUL_RUN;
                            cnt_nxt     = '0;
                            prod_nxt    = '0;
                            mcand_nxt   = {{WIDTH{1'b0}}, mag_ac};
                            mplier_nxt  = mag_z;
                            neg_res_nxt = ac[WIDTH-1] ^ Z[WIDTH-1];
                        end
                        default: ;
                    endcase
                end
            end
            MUL_RUN: begin
                prod_nxt   = prod_fin;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ac_nxt    = mul_val;
                    done_nxt  = 1'b1;
                    if (mul_ovf) ovf_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ac      <= '0;
            ovf     <= 1'b0;
            done_q  <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            neg_res <= 1'b0;
        end else begin
            state   <= state_nxt;
            ac      <= ac_nxt;
            ovf     <= ovf_nxt;
            done_q  <= done_nxt;
            cnt     <= cnt_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            prod    <= prod_nxt;
            neg_res <= neg_res_nxt;
        end
    end

    assign AC   = ac;
    assign OVF  = ovf;
    assign done = done_q;
    assign busy = (state == MUL_RUN);
    assign ZF   = (ac == '0);
    assign NF   = ac[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_ac_unit.sv
`default_nettype none
// Bench for ac_unit: a saturating and a wrapping instance share stimulus;
// directed table, multiply/reset sequences and random traffic vs. a model.
module tb_ac_unit;

    localparam int W    = 8;
    localparam int MAXV = 2**(W-1) - 1;
    localparam int MINV = -(2**(W-1));

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           CLR = 3'd4, NEG = 3'd5, MUL = 3'd6, RSV = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] z = '0;
    logic [2:0] op = '0;
    logic op_valid = 1'b0;

    logic signed [W-1:0] ac_s, ac_w;
    logic busy_s, done_s, ovf_s, zf_s, nf_s;
    logic busy_w, done_w, ovf_w, zf_w, nf_w;

    ac_unit #(.WIDTH(W), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .Z(z), .op(op), .op_valid(op_valid),
        .AC(ac_s), .busy(busy_s), .done(done_s), .OVF(ovf_s), .ZF(zf_s), .NF(nf_s)
    );

    ac_unit #(.WIDTH(W), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .Z(z), .op(op), .op_valid(op_valid),
        .AC(ac_w), .busy(busy_w), .done(done_w), .OVF(ovf_w), .ZF(zf_w), .NF(nf_w)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model, index 0 = saturating, 1 = wrapping
    int m_ac[2];
    bit m_ovf[2];
    int m_cnt[2];
    int m_pend[2];
    bit m_done[2];

    typedef struct {
        bit         v;
        logic [2:0] o;
        int         zz;
        int         ac_sat;
        bit         ovf_sat;
        int         ac_wrap;
        bit         ovf_wrap;
    } vec_t;

    vec_t tbl[13];

    function automatic int wrapw(input int val);
        logic [W-1:0] t;
        t = val[W-1:0];
        return int'($signed(t));
    endfunction

    task automatic resolve(input int k, input int val);
        if (val > MAXV || val < MINV) begin
            m_ovf[k] = 1'b1;
            m_ac[k]  = (k == 0) ? ((val > 0) ? MAXV : MINV) : wrapw(val);
        end else begin
            m_ac[k] = val;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ac[k] = 0; m_ovf[k] = 1'b0; m_cnt[k] = 0; m_pend[k] = 0; m_done[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit v, input logic [2:0] o, input int zz);
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (m_cnt[k] > 0) begin
                m_cnt[k]--;
                if (m_cnt[k] == 0) begin
                    resolve(k, m_pend[k]);
                    m_done[k] = 1'b1;
                end
            end else if (v) begin
                case (o)
                    LOAD: begin m_ac[k] = zz; m_ovf[k] = 1'b0; end
                    ADD:  resolve(k, m_ac[k] + zz);
                    SUB:  resolve(k, m_ac[k] - zz);
                    CLR:  begin m_ac[k] = 0; m_ovf[k] = 1'b0; end
                    NEG:  resolve(k, -m_ac[k]);
                    MUL:  begin m_pend[k] = m_ac[k] * zz; m_cnt[k] = W; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input int k, input string tag, input int eac, input bit eovf,
                           input bit ebusy, input bit edone);
        int a; bit ov, bz, dn, zf, nf;
        string p;
        if (k == 0) begin
            a = int'(ac_s); ov = ovf_s; bz = busy_s; dn = done_s; zf = zf_s; nf = nf_s; p = "sat";
        end else begin
            a = int'(ac_w); ov = ovf_w; bz = busy_w; dn = done_w; zf = zf_w; nf = nf_w; p = "wrap";
        end
        chk($sformatf("%s %s AC", p, tag), a, eac);
        chk($sformatf("%s %s OVF", p, tag), int'(ov), int'(eovf));
        chk($sformatf("%s %s busy", p, tag), int'(bz), int'(ebusy));
        chk($sformatf("%s %s done", p, tag), int'(dn), int'(edone));
        chk($sformatf("%s %s ZF", p, tag), int'(zf), int'(eac == 0));
        chk($sformatf("%s %s NF", p, tag), int'(nf), int'(eac < 0));
    endtask

    task automatic chk_model(input string tag);
        for (int k = 0; k < 2; k++)
            chk_dut(k, tag, m_ac[k], m_ovf[k], m_cnt[k] > 0, m_done[k]);
    endtask

    task automatic apply(input bit v, input logic [2:0] o, input int zz);
        op_valid = v;
        op       = o;
        z        = zz[W-1:0];
        @(posedge clk);
        model_edge(v, o, zz);
        #1;
    endtask

    // MUL with an ignored ADD 1 issued while busy; AC must stay 'pre' until E+W
    task automatic mul_seq(input string tag, input int zz, input int pre,
                           input int e_sat, input int e_wrap, input bit e_ovf);
        apply(1'b1, MUL, zz);
        chk_dut(0, {tag, " accept"}, pre, 1'b0, 1'b1, 1'b0);
        chk_dut(1, {tag, " accept"}, pre, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= W; i++) begin
            apply(i == 3, ADD, 1);
            if (i < W) begin
                chk_dut(0, {tag, " run"}, pre, 1'b0, 1'b1, 1'b0);
                chk_dut(1, {tag, " run"}, pre, 1'b0, 1'b1, 1'b0);
            end else begin
                chk_dut(0, {tag, " result"}, e_sat, e_ovf, 1'b0, 1'b1);
                chk_dut(1, {tag, " result"}, e_wrap, e_ovf, 1'b0, 1'b1);
            end
        end
        apply(1'b0, NOP, 0);
        chk_dut(0, {tag, " after"}, e_sat, e_ovf, 1'b0, 1'b0);
        chk_dut(1, {tag, " after"}, e_wrap, e_ovf, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, LOAD, 100,  100, 1'b0,  100, 1'b0};
        tbl[1]  = '{1'b1, ADD,   50,  127, 1'b1, -106, 1'b1};
        tbl[2]  = '{1'b1, LOAD,   5,    5, 1'b0,    5, 1'b0};
        tbl[3]  = '{1'b1, SUB,   10,   -5, 1'b0,   -5, 1'b0};
        tbl[4]  = '{1'b1, LOAD, -128, -128, 1'b0, -128, 1'b0};
        tbl[5]  = '{1'b1, SUB,    1, -128, 1'b1,  127, 1'b1};
        tbl[6]  = '{1'b1, CLR,    9,    0, 1'b0,    0, 1'b0};
        tbl[7]  = '{1'b1, LOAD, -128, -128, 1'b0, -128, 1'b0};
        tbl[8]  = '{1'b1, NEG,    0,  127, 1'b1, -128, 1'b1};
        tbl[9]  = '{1'b1, NOP,   33,  127, 1'b1, -128, 1'b1};
        tbl[10] = '{1'b1, RSV,   33,  127, 1'b1, -128, 1'b1};
        tbl[11] = '{1'b0, ADD,    5,  127, 1'b1, -128, 1'b1};
        tbl[12] = '{1'b1, LOAD,  20,   20, 1'b0,   20, 1'b0};

        model_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_dut(0, "reset", 0, 1'b0, 1'b0, 1'b0);
        chk_dut(1, "reset", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].v, tbl[i].o, tbl[i].zz);
            chk_dut(0, $sformatf("vec%0d", i), tbl[i].ac_sat, tbl[i].ovf_sat, 1'b0, 1'b0);
            chk_dut(1, $sformatf("vec%0d", i), tbl[i].ac_wrap, tbl[i].ovf_wrap, 1'b0, 1'b0);
        end

        mul_seq("mul20x16", 16, 20, 127, 64, 1'b1);
        apply(1'b1, LOAD, -7);
        mul_seq("mul-7x9", 9, -7, -63, -63, 1'b0);
        apply(1'b1, LOAD, -128);
        mul_seq("mul-128x-1", -1, -128, 127, -128, 1'b1);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            apply($urandom_range(0, 3) != 0,
                  (r < 2) ? LOAD : (r == 9) ? MUL : 3'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)) - 128);
            chk_model("rand");
        end
        for (int i = 0; i <= W; i++) begin
            apply(1'b0, NOP, 0);
            chk_model("drain");
        end

        // Asynchronous reset part-way through a multiply
        apply(1'b1, LOAD, 20);
        apply(1'b1, MUL, 16);
        apply(1'b0, NOP, 0);
        apply(1'b0, NOP, 0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk_model("async rst");
        @(posedge clk);
        #1;
        chk_model("rst held");
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            apply(1'b0, NOP, 0);
            chk_model("post rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
